// File: rtl/updown_counter_4_if.sv
// Control and status bundle for updown_counter_4.
// The counter uses the slave modport; the block that drives it uses master.
interface updown_counter_4_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (
    output en, dir, load, d,
    input  q, tc, wrap
  );

  modport slave (
    input  en, dir, load, d,
    output q, tc, wrap
  );
endinterface

// File: rtl/updown_counter_4.sv
// Up/down counter with enable, parallel load (load > en > hold), combinational tc, registered wrap pulse.
// Latency: q and wrap update one core_clk edge after sampling; tc is same-cycle. No backpressure.
// Define UPDOWN_COUNTER_SAT_EN to saturate at the boundaries instead of wrapping (wrap then stays 0).
module updown_counter_4 #(
  parameter int WIDTH = 4
) (
  input  logic               core_clk,
  input  logic               arst_n,
  updown_counter_4_if.slave  bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] q_d, q_q;
  logic             wrap_d, wrap_q;
  logic             at_top, at_bot, at_edge;

  assign at_top  = (q_q == ALL_ONES);
  assign at_bot  = (q_q == '0);
  // True when the next step in the current direction would leave the range.
  assign at_edge = bus.dir ? at_top : at_bot;

  assign bus.tc   = bus.en & ~bus.load & at_edge;
  assign bus.q    = q_q;
  assign bus.wrap = wrap_q;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      q_d = bus.d;
    end else if (bus.en) begin
`ifdef UPDOWN_COUNTER_SAT_EN
      if (!at_edge) begin
        q_d = bus.dir ? (q_q + ONE) : (q_q - ONE);
      end
`else
      q_d    = bus.dir ? (q_q + ONE) : (q_q - ONE);
      wrap_d = at_edge;
`endif
    end
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

endmodule

// File: tb/tb_updown_counter_4.sv
// Directed-vector bench for updown_counter_4: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares q, tc and wrap.
module tb_updown_counter_4;

  typedef struct packed {
    logic [3:0] q;
    logic       tc;
    logic       wrap;
  } exp_t;

  logic core_clk = 1'b0;
  logic arst_n   = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   row      = 0;
  exp_t sb[$];

  updown_counter_4_if #(.WIDTH(4)) bus ();

  updown_counter_4 #(.WIDTH(4)) dut (
    .core_clk (core_clk),
    .arst_n   (arst_n),
    .bus      (bus.slave)
  );

  always #5 core_clk = ~core_clk;

  // Inputs apply 1 time unit after a rising edge; expectations are what the
  // monitor must see at the following falling edge (q is the pre-edge value).
  task automatic vec(input logic rst_n_i, input logic en_i, input logic dir_i,
                     input logic load_i, input logic [3:0] d_i,
                     input logic [3:0] eq, input logic etc, input logic ewrap);
    exp_t e;
    @(posedge core_clk);
    #1;
    arst_n   = rst_n_i;
    bus.en   = en_i;
    bus.dir  = dir_i;
    bus.load = load_i;
    bus.d    = d_i;
    e.q      = eq;
    e.tc     = etc;
    e.wrap   = ewrap;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge core_clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks += 3;
        if (bus.q !== e.q) begin
          n_fail++;
          $display("FAIL row%0d q: got %0d expected %0d", row, bus.q, e.q);
        end
        if (bus.tc !== e.tc) begin
          n_fail++;
          $display("FAIL row%0d tc: got %b expected %b", row, bus.tc, e.tc);
        end
        if (bus.wrap !== e.wrap) begin
          n_fail++;
          $display("FAIL row%0d wrap: got %b expected %b", row, bus.wrap, e.wrap);
        end
        row++;
      end
    end
  end

  initial begin : stimulus
    bus.en   = 1'b0;
    bus.dir  = 1'b0;
    bus.load = 1'b0;
    bus.d    = 4'd0;

    //  rst en dir ld d      q    tc wrap
    vec(0, 0, 0, 0, 4'd0,  4'd0, 0, 0);   // in reset
    vec(1, 1, 1, 0, 4'd0,  4'd0, 0, 0);   // release, count up
    vec(1, 1, 1, 0, 4'd0,  4'd1, 0, 0);
    vec(1, 1, 1, 0, 4'd0,  4'd2, 0, 0);
    vec(1, 1, 1, 0, 4'd0,  4'd3, 0, 0);
    vec(1, 1, 1, 0, 4'd0,  4'd4, 0, 0);
    vec(1, 1, 0, 0, 4'd0,  4'd5, 0, 0);   // count down
    vec(1, 1, 0, 0, 4'd0,  4'd4, 0, 0);
    vec(1, 1, 0, 0, 4'd0,  4'd3, 0, 0);
    vec(1, 0, 0, 0, 4'd0,  4'd2, 0, 0);   // enable gating
    vec(1, 0, 1, 0, 4'd0,  4'd2, 0, 0);
    vec(1, 0, 0, 1, 4'd14, 4'd2, 0, 0);   // load 14
`ifdef UPDOWN_COUNTER_SAT_EN
    vec(1, 1, 1, 0, 4'd0,  4'd14, 0, 0);
    vec(1, 1, 1, 0, 4'd0,  4'd15, 1, 0);  // up at top: holds
    vec(1, 0, 1, 0, 4'd0,  4'd15, 0, 0);
    vec(1, 1, 0, 0, 4'd0,  4'd15, 0, 0);
    vec(1, 0, 0, 0, 4'd0,  4'd14, 0, 0);
    vec(1, 0, 0, 0, 4'd0,  4'd14, 0, 0);
    vec(1, 1, 1, 1, 4'd9,  4'd14, 0, 0);  // load beats en
    vec(1, 0, 0, 0, 4'd0,  4'd9,  0, 0);
    vec(1, 1, 1, 0, 4'd0,  4'd9,  0, 0);
    vec(1, 0, 0, 0, 4'd0,  4'd10, 0, 0);
    vec(0, 1, 0, 0, 4'd0,  4'd0,  1, 0);  // async reset between edges
    vec(1, 1, 0, 0, 4'd0,  4'd0,  1, 0);  // down at 0: holds
    vec(1, 0, 0, 0, 4'd0,  4'd0,  0, 0);
    vec(1, 1, 1, 0, 4'd0,  4'd0,  0, 0);
    vec(1, 1, 0, 0, 4'd0,  4'd1,  0, 0);
    vec(1, 0, 0, 0, 4'd0,  4'd0,  0, 0);
`else
    vec(1, 1, 1, 0, 4'd0,  4'd14, 0, 0);
    vec(1, 1, 1, 0, 4'd0,  4'd15, 1, 0);  // up at top: wraps
    vec(1, 0, 1, 0, 4'd0,  4'd0,  0, 1);
    vec(1, 1, 0, 0, 4'd0,  4'd0,  1, 0);  // down at 0: wraps
    vec(1, 0, 0, 0, 4'd0,  4'd15, 0, 1);
    vec(1, 0, 0, 0, 4'd0,  4'd15, 0, 0);  // pulse lasts one cycle
    vec(1, 1, 1, 1, 4'd9,  4'd15, 0, 0);  // load masks tc and beats en
    vec(1, 0, 0, 0, 4'd0,  4'd9,  0, 0);
    vec(1, 1, 1, 0, 4'd0,  4'd9,  0, 0);
    vec(1, 0, 0, 0, 4'd0,  4'd10, 0, 0);
    vec(0, 1, 0, 0, 4'd0,  4'd0,  1, 0);  // async reset between edges
    vec(1, 1, 0, 0, 4'd0,  4'd0,  1, 0);  // first edge after release
    vec(1, 0, 0, 0, 4'd0,  4'd15, 0, 1);
    vec(1, 1, 1, 0, 4'd0,  4'd15, 1, 0);
    vec(1, 1, 0, 0, 4'd0,  4'd0,  1, 1);  // direction flip at 0
    vec(1, 0, 0, 0, 4'd0,  4'd15, 0, 1);
`endif

    repeat (3) @(posedge core_clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
